// File: rtl/cordic_vec_ctrl.sv
// cordic_vec_ctrl: sequencer for an iterative CORDIC vectoring engine.
// One external combinational add/sub unit is time-shared across the X, Y and
// Z updates of each micro-rotation. The vector is first folded into the right
// half-plane when x_in is negative. The block then runs ITERATIONS
// micro-rotations and returns the unscaled magnitude (times K ~ 1.6468) and the
// angle in Q2.13 radians.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; ALU driven with ADD 0 + 0
// PRE_X  | X <- 0 - X (left half-plane fold)
// PRE_Y  | Y <- 0 - Y, sigma from the folded Y
// IT_X   | x_tmp <- X -/+ (Y >>> i)
// IT_Y   | Y <- Y +/- (X >>> i), using the X from before this iteration
// IT_Z   | Z <- Z -/+ ATAN[i], commit X, advance i, next sigma
// DONE   | one-cycle done pulse, results already registered

module cordic_vec_ctrl #(
    parameter int WORD_WIDTH = 16,
    parameter int ITERATIONS = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] x_in,
    input  logic [WORD_WIDTH-1:0] y_in,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] x_out,
    output logic [WORD_WIDTH-1:0] z_out,
    output logic                  alu_operation,
    output logic [WORD_WIDTH-1:0] alu_a,
    output logic [WORD_WIDTH-1:0] alu_b,
    input  logic [WORD_WIDTH-1:0] alu_result
);

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // pi in Q2.13, used as the starting angle after a left half-plane fold
    localparam logic signed [WORD_WIDTH-1:0] PI_POS = WORD_WIDTH'(25736);
    localparam logic signed [WORD_WIDTH-1:0] PI_NEG = WORD_WIDTH'(-25736);

    localparam logic [3:0] LAST_IDX = 4'(ITERATIONS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE_X = 3'd1,
        S_PRE_Y = 3'd2,
        S_IT_X  = 3'd3,
        S_IT_Y  = 3'd4,
        S_IT_Z  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [WORD_WIDTH-1:0] x_reg;
    logic signed [WORD_WIDTH-1:0] y_reg;
    logic signed [WORD_WIDTH-1:0] z_reg;
    logic signed [WORD_WIDTH-1:0] x_tmp;
    logic [3:0]                   i_cnt;
    logic                         sigma;
    logic [WORD_WIDTH-1:0]        x_out_reg;
    logic [WORD_WIDTH-1:0]        z_out_reg;

    logic signed [WORD_WIDTH-1:0] x_shift;
    logic signed [WORD_WIDTH-1:0] y_shift;
    logic                         last_iter;

    // round(atan(2^-i) * 8192); the last two entries saturate at the Q2.13 LSB
    function automatic logic signed [WORD_WIDTH-1:0] atan_lut(input logic [3:0] idx);
        logic signed [WORD_WIDTH-1:0] val;
        case (idx)
            4'd0:    val = WORD_WIDTH'(6434);
            4'd1:    val = WORD_WIDTH'(3798);
            4'd2:    val = WORD_WIDTH'(2007);
            4'd3:    val = WORD_WIDTH'(1019);
            4'd4:    val = WORD_WIDTH'(511);
            4'd5:    val = WORD_WIDTH'(256);
            4'd6:    val = WORD_WIDTH'(128);
            4'd7:    val = WORD_WIDTH'(64);
            4'd8:    val = WORD_WIDTH'(32);
            4'd9:    val = WORD_WIDTH'(16);
            4'd10:   val = WORD_WIDTH'(8);
            4'd11:   val = WORD_WIDTH'(4);
            4'd12:   val = WORD_WIDTH'(2);
            4'd13:   val = WORD_WIDTH'(1);
            4'd14:   val = WORD_WIDTH'(1);
            default: val = WORD_WIDTH'(0);
        endcase
        return val;
    endfunction

    assign x_shift   = x_reg >>> i_cnt;
    assign y_shift   = y_reg >>> i_cnt;
    assign last_iter = (i_cnt == LAST_IDX);

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign x_out = x_out_reg;
    assign z_out = z_out_reg;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and ALU operand/operation selection
    always_comb begin
        state_nxt     = state;
        alu_operation = ALU_ADD;
        alu_a         = '0;
        alu_b         = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = x_in[WORD_WIDTH-1] ? S_PRE_X : S_IT_X;
                end
            end
            S_PRE_X: begin
                alu_operation = ALU_SUB;
                alu_b         = x_reg;
                state_nxt     = S_PRE_Y;
            end
            S_PRE_Y: begin
                alu_operation = ALU_SUB;
                alu_b         = y_reg;
                state_nxt     = S_IT_X;
            end
            S_IT_X: begin
                // sigma=1 (Y >= 0): rotate clockwise, X grows by Y>>>i
                alu_operation = sigma ? ALU_ADD : ALU_SUB;
                alu_a         = x_reg;
                alu_b         = y_shift;
                state_nxt     = S_IT_Y;
            end
            S_IT_Y: begin
                alu_operation = sigma ? ALU_SUB : ALU_ADD;
                alu_a         = y_reg;
                alu_b         = x_shift;
                state_nxt     = S_IT_Z;
            end
            S_IT_Z: begin
                alu_operation = sigma ? ALU_ADD : ALU_SUB;
                alu_a         = z_reg;
                alu_b         = atan_lut(i_cnt);
                state_nxt     = last_iter ? S_DONE : S_IT_X;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath registers; results are captured on the edge that enters DONE
    // so x_out/z_out are already valid while done is high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            x_tmp     <= '0;
            i_cnt     <= '0;
            sigma     <= 1'b0;
            x_out_reg <= '0;
            z_out_reg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_reg <= x_in;
                        y_reg <= y_in;
                        i_cnt <= '0;
                        if (x_in[WORD_WIDTH-1]) begin
                            z_reg <= y_in[WORD_WIDTH-1] ? PI_NEG : PI_POS;
                        end else begin
                            z_reg <= '0;
                            sigma <= ~y_in[WORD_WIDTH-1];
                        end
                    end
                end
                S_PRE_X: begin
                    x_reg <= alu_result;
                end
                S_PRE_Y: begin
                    y_reg <= alu_result;
                    sigma <= ~alu_result[WORD_WIDTH-1];
                end
                S_IT_X: begin
                    x_tmp <= alu_result;
                end
                S_IT_Y: begin
                    y_reg <= alu_result;
                end
                S_IT_Z: begin
                    z_reg <= alu_result;
                    x_reg <= x_tmp;
                    i_cnt <= i_cnt + 4'd1;
                    sigma <= ~y_reg[WORD_WIDTH-1];
                    if (last_iter) begin
                        x_out_reg <= x_tmp;
                        z_out_reg <= alu_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
